// File: rtl/bus_dir_pkg.sv
// bus_dir_pkg -- shared types and constants for the bus direction controller.
// Holds the FSM state encoding, the default TURN / LEN_W values and the
// transceiver direction encodings used by bus_dir_ctrl and its counter.
package bus_dir_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETUP   = 2'd1,
      ST_XFER    = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   localparam int TURN_DEF  = 2;
   localparam int LEN_W_DEF = 4;

   // Transceiver DIR pin encoding.
   localparam logic DIR_AB = 1'b1;
   localparam logic DIR_BA = 1'b0;

   // The shared counter must hold both TURN-1 (at most 6, three bits) and a
   // full beat length, so it is as wide as whichever needs more bits.
   function automatic int cnt_width(input int len_w);
      return (len_w > 3) ? len_w : 3;
   endfunction

endpackage

// File: rtl/dir_ctrl_cnt.sv
// dir_ctrl_cnt -- loadable down-counter with zero flag.
// A single instance times both the turnaround (SETUP) interval and the
// beat (XFER) interval of bus_dir_ctrl. Load wins over decrement, and the
// count saturates at zero rather than wrapping.
module dir_ctrl_cnt
   import bus_dir_pkg::*;
#(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Counter register: load a new interval, otherwise count down to zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (dec && (cnt != '0)) begin
         cnt <= cnt - W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/bus_dir_ctrl.sv
// bus_dir_ctrl -- direction / enable sequencer for a bidirectional bus
// transceiver (active-low enable g, direction dir).
// A granted transfer runs IDLE -> SETUP -> XFER -> RELEASE. SETUP keeps the
// transceiver isolated for TURN cycles when the direction flips (1 cycle
// otherwise), XFER enables it for len+1 beats, RELEASE isolates it again
// and pulses done.
// Optional build macro: FAIR_ARB_EN -- when defined, simultaneous requests
// alternate against the last served direction instead of favouring A->B.
module bus_dir_ctrl
   import bus_dir_pkg::*;
#(
   parameter int TURN  = TURN_DEF,
   parameter int LEN_W = LEN_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_ab,
   input  logic             req_ba,
   input  logic [LEN_W-1:0] len,
   output logic             g,
   output logic             dir,
   output logic             beat,
   output logic             done,
   output logic             busy
);

   localparam int CNT_W = cnt_width(LEN_W);

   state_t             state;
   state_t             state_nxt;
   // dir_q is updated only at grant, so it also serves as the
   // last-served direction for the fair arbiter.
   logic               dir_q;
   logic [LEN_W-1:0]   len_q;
   logic               req_any;
   logic               grant;
   logic               grant_dir;
   logic [CNT_W-1:0]   turn_val;
   logic               cnt_load;
   logic               cnt_dec;
   logic [CNT_W-1:0]   cnt_val;
   logic               cnt_zero;

   dir_ctrl_cnt #(
      .W (CNT_W)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Arbitration: pick the direction to grant and its SETUP length.
   always_comb begin
      req_any = req_ab | req_ba;
`ifdef FAIR_ARB_EN
      if (req_ab && req_ba) begin
         grant_dir = ~dir_q;
      end else begin
         grant_dir = req_ab ? DIR_AB : DIR_BA;
      end
`else
      grant_dir = req_ab ? DIR_AB : DIR_BA;
`endif
      // Counter runs from turn_val down to zero, so SETUP lasts turn_val+1.
      turn_val = (grant_dir != dir_q) ? CNT_W'(TURN - 1) : '0;
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and counter control.
   // NOTE: every output of this block gets a default first, so no path
   // through the case statement can leave a latch behind.
   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      cnt_load  = 1'b0;
      cnt_dec   = 1'b0;
      cnt_val   = turn_val;
      unique case (state)
         ST_IDLE: begin
            if (req_any) begin
               grant     = 1'b1;
               cnt_load  = 1'b1;
               state_nxt = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (cnt_zero) begin
               cnt_load  = 1'b1;
               cnt_val   = CNT_W'(len_q);
               state_nxt = ST_XFER;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_XFER: begin
            if (cnt_zero) begin
               state_nxt = ST_RELEASE;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         ST_RELEASE: begin
            // A request still held at the end of a transfer goes straight
            // into the next SETUP, so the transceiver is isolated for only
            // RELEASE plus SETUP between back-to-back transfers.
            if (req_any) begin
               grant     = 1'b1;
               cnt_load  = 1'b1;
               state_nxt = ST_SETUP;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Grant-time capture of direction and beat length.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dir_q <= DIR_BA;
         len_q <= '0;
      end else if (grant) begin
         dir_q <= grant_dir;
         len_q <= len;
      end
   end

   // Output decode: purely from state so reset forces them immediately.
   always_comb begin
      g    = 1'b1;
      beat = 1'b0;
      done = 1'b0;
      busy = 1'b1;
      unique case (state)
         ST_IDLE:    busy = 1'b0;
         ST_SETUP:   g    = 1'b1;
         ST_XFER: begin
            g    = 1'b0;
            beat = 1'b1;
         end
         ST_RELEASE: done = 1'b1;
         default:    busy = 1'b0;
      endcase
   end

   assign dir = dir_q;

endmodule

// File: tb/tb_bus_dir_ctrl.sv
// tb_bus_dir_ctrl -- self-checking bench for bus_dir_ctrl (TURN=2, LEN_W=4).
// Directed steps push expected transfers into a scoreboard; a negedge
// monitor measures each transfer the DUT produces and pops/compares.
// Honours FAIR_ARB_EN for the expected arbitration outcome.
module tb_bus_dir_ctrl;

   localparam int TURN  = 2;
   localparam int LEN_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             req_ab;
   logic             req_ba;
   logic [LEN_W-1:0] len;
   logic             g;
   logic             dir;
   logic             beat;
   logic             done;
   logic             busy;

   typedef struct {
      logic d;
      int   setup;
      int   beats;
      int   gap;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;
   logic mdl_dir = 1'b0;

   bus_dir_ctrl #(
      .TURN  (TURN),
      .LEN_W (LEN_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .req_ab (req_ab),
      .req_ba (req_ba),
      .len    (len),
      .g      (g),
      .dir    (dir),
      .beat   (beat),
      .done   (done),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Expected outcome of one grant, from the arbitration rules.
   task automatic push_exp(input logic ab, input logic ba, input int l, input bit first);
      exp_t e;
      logic d;
`ifdef FAIR_ARB_EN
      d = (ab && ba) ? ~mdl_dir : (ab ? 1'b1 : 1'b0);
`else
      d = ab ? 1'b1 : 1'b0;
`endif
      e.d     = d;
      e.setup = (d != mdl_dir) ? TURN : 1;
      e.beats = l + 1;
      e.gap   = first ? -1 : 1 + e.setup;
      mdl_dir = d;
      sb.push_back(e);
   endtask

   // Monitor: measures SETUP length, g-high gap, beats and direction.
   int   setup_n  = 0;
   int   beat_n   = 0;
   int   gap_n    = 0;
   logic prev_dir = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         setup_n  = 0;
         beat_n   = 0;
         gap_n    = 0;
         prev_dir = dir;
      end else begin
         if (!g) chk("dir_stable", 32'(dir), 32'(prev_dir));
         if (beat) begin
            if (beat_n == 0 && sb.size() > 0) begin
               chk("setup_len", setup_n, sb[0].setup);
               if (sb[0].gap >= 0) chk("g_gap", gap_n, sb[0].gap);
            end
            beat_n++;
            gap_n = 0;
         end else if (busy && g) begin
            gap_n++;
            if (!done) setup_n++;
         end
         if (done) begin
            chk("done_beat_low", 32'(beat), 32'd0);
            chk("spurious_done", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               chk("xfer_dir", 32'(dir), 32'(e.d));
               chk("beats", beat_n, e.beats);
            end
            setup_n = 0;
            beat_n  = 0;
         end
         prev_dir = dir;
      end
   end

   // Drive one request pattern for n grants, then release it.
   task automatic run(input logic ab, input logic ba, input int l, input int n,
                      input bit drop_early);
      int seen = 0;
      int cyc  = 0;
      for (int i = 0; i < n; i++) push_exp(ab, ba, l, i == 0);
      @(negedge clk);
      rst    = 1'b0;
      req_ab = ab;
      req_ba = ba;
      len    = LEN_W'(l);
      @(posedge clk);
      #1;
      chk("grant_at_edge", 32'(busy), 32'd1);
      if (drop_early) begin
         req_ab = 1'b0;
         req_ba = 1'b0;
         len    = ~len;
      end
      while (seen < n && cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (done) begin
            seen++;
            if (seen == n) begin
               req_ab = 1'b0;
               req_ba = 1'b0;
            end
         end
      end
      chk("run_timeout", seen, n);
      @(posedge clk);
      #1;
      chk("idle_after", 32'(busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb;
      int cyc;
      rst    = 1'b1;
      req_ab = 1'b0;
      req_ba = 1'b0;
      len    = '0;
      #1;
      chk("rst_g",    32'(g),    32'd1);
      chk("rst_dir",  32'(dir),  32'd0);
      chk("rst_beat", 32'(beat), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);

      // Single A->B, len=3, request dropped right after grant.
      run(1'b1, 1'b0, 3, 1, 1'b1);
      // A->B followed by B->A with one beat.
      run(1'b0, 1'b1, 0, 1, 1'b0);
      // Back-to-back A->B: first flips direction, second does not.
      run(1'b1, 1'b0, 2, 2, 1'b0);
      // Simultaneous requests held for four grants.
      run(1'b1, 1'b1, 0, 4, 1'b0);
      // Longest transfer: 16 beats.
      run(1'b1, 1'b0, 15, 1, 1'b0);

      // Reset in the third XFER cycle, then recovery with request held.
      @(negedge clk);
      req_ab = 1'b1;
      len    = 4'd5;
      nb     = 0;
      cyc    = 0;
      while (nb < 3 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (beat) nb++;
      end
      chk("reach_xfer3", nb, 3);
      rst = 1'b1;
      #1;
      chk("midrst_g",    32'(g),    32'd1);
      chk("midrst_beat", 32'(beat), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_dir",  32'(dir),  32'd0);
      mdl_dir = 1'b0;
      @(negedge clk);
      chk("midrst_no_done", 32'(done), 32'd0);
      run(1'b1, 1'b0, 1, 1, 1'b0);

      // Lone B->A after recovery.
      run(1'b0, 1'b1, 4, 1, 1'b0);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
